mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-master, one-slave arbiter that shares a single memory or peripheral port between the core's instruction fetch path (read-only) and its load/store path (read/write). It sits between the core bus masters and a single-ported memory. It accepts one request at a time, latches its attributes, drives the slave for a fixed access latency, and returns data and error status to the winning master with a one-cycle acknowledge pulse.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width.
- `LATENCY`, 1: cycles from the first slave-drive cycle to the cycle in which `s_rdata`/`s_err` are valid. Legal range is 1..7.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  instruction master request; held until `i_ack`.
- `i_addr`  in  AW  instruction fetch address; always a full word (`tsize` = word).
- `i_rdata`  out  DW  fetch data; valid only while `i_ack`=1.
- `i_ack`  out  1  one-cycle completion pulse for the instruction master.
- `i_err`  out  1  error flag, qualified by `i_ack`.
- `d_req`  in  1  data master request; held until `d_ack`.
- `d_we`  in  1  1 selects write, 0 selects read.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  write data.
- `d_tsize`  in  2  transfer size: 0 byte, 1 half, 2 word.
- `d_rdata`  out  DW  read data; valid only while `d_ack`=1; 0 on write acks.
- `d_ack`  out  1  one-cycle completion pulse for the data master.
- `d_err`  out  1  error flag, qualified by `d_ack`.
- `s_valid`  out  1  slave access in progress.
- `s_write`  out  1  slave write strobe; qualified by `s_valid`.
- `s_addr`  out  AW  latched address to the slave.
- `s_wdata`  out  DW  latched write data to the slave.
- `s_tsize`  out  2  latched transfer size (2 for instruction fetches).
- `s_rdata`  in  DW  slave read data.
- `s_err`  in  1  slave read/write error (rerror or werror).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any request is present, select a winner, latch owner, addr, wdata, tsize and write, load `cnt`=LATENCY, and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - `s_valid`=1; `s_write`=latched write.
  - `s_addr`, `s_wdata` and `s_tsize` come from the latched copy and are stable for the whole state.
  - `cnt` decrements each cycle.
  - In the cycle where `cnt`=1, capture `s_rdata` (forced to 0 for writes) and `s_err`, then go to RESP.
- **RESP**
  - Pulse the owner's ack for exactly one cycle, with the captured rdata/err on that master's outputs.
  - The other master's ack stays 0.
  - Next state is always IDLE.
- Instruction requests are always issued as reads of `tsize`=2.
- Masters must not change request attributes between req and ack. The arbiter uses only its latched copy, so a master dropping req mid-access still gets its ack.
- The request signal is re-examined only in IDLE. A req still high in the cycle after ack is treated as a new request.
- Arbitration on simultaneous `i_req` and `d_req` in IDLE is set by the macro (see Configuration). A lone requester always wins.
- On reset, including mid-transaction:
  - State goes to IDLE; `cnt`=0.
  - `last_grant`=instruction.
  - All outputs are 0: every ack, err, rdata, `s_valid`, `s_write`, `s_addr`, `s_wdata` and `s_tsize`.
  - An in-flight access is aborted and no ack is produced.

## Timing
- Cycle 0: IDLE samples req.
- Cycles 1..LATENCY: ACCESS, with `s_valid`=1.
- Cycle LATENCY+1: ack pulse (RESP).
- Cycle LATENCY+2: IDLE again, so the earliest next grant is sampled here.
- Request-to-ack latency is LATENCY+1 cycles.
- Back-to-back throughput is one transaction per LATENCY+2 cycles.
- `s_*` outputs and all master rdata/ack/err outputs are registered; there is no combinational path from master inputs to any output.
- Outside ACCESS, `s_valid`=`s_write`=0. `s_addr`, `s_wdata` and `s_tsize` hold their last values.
- Outside RESP, every ack and err is 0.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration. On a conflict the master not recorded in `last_grant` wins. `last_grant` updates on every grant. After reset the first conflict goes to the data master.
- Not defined: fixed priority, where the data master always wins a conflict. `last_grant` is not implemented.

## Test plan
- **Single fetch** (LATENCY=1): pulse `i_req` with `i_addr`=0x100; the slave returns 0xDEADBEEF.
  - `s_valid` is high in cycle 1 with `s_addr`=0x100, `s_write`=0 and `s_tsize`=2.
  - `i_ack`=1 in cycle 2 with `i_rdata`=0xDEADBEEF; `d_ack` stays 0.
- **Byte write** (LATENCY=3): `d_req`, `d_we`=1, `d_addr`=0x204, `d_wdata`=0xAB, `d_tsize`=0.
  - `s_write` is high in cycles 1–3.
  - `d_ack` is high in cycle 4 with `d_rdata`=0 and `d_err`=0.
- **Conflict, round-robin build**: `i_req` and `d_req` held high from reset.
  - Grants go D, I, D, I.
  - Acks appear at cycles 2, 5, 8, 11 for LATENCY=1.
- **Conflict, fixed-priority build**: both requests held high.
  - Only `d_ack` pulses, every 3 cycles.
  - `i_ack` stays 0 until `d_req` drops, then `i_ack` follows 3 cycles later.
- **Error propagation**: the slave asserts `s_err`=1 on a read of 0xFFFF_FFF0.
  - The requester's ack and err are both high in the same cycle; err is 0 in every other cycle.
- **Reset mid-access** (LATENCY=3): assert `rst_n`=0 in cycle 2 of ACCESS.
  - All outputs drop to 0 immediately.
  - No ack is ever issued for that request.
  - A request after reset is released completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: instruction master, data master and slave port.
// The "master" modport is the environment side: the core masters and the memory
// together drive requests and slave responses. The "slave" modport is the arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Instruction master (read-only, always word sized)
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          i_err;
  // Data master (read/write)
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [1:0]    d_tsize;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          d_err;
  // Shared slave port
  logic          s_valid;
  logic          s_write;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [1:0]    s_tsize;
  logic [DW-1:0] s_rdata;
  logic          s_err;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_tsize, s_rdata, s_err,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           s_valid, s_write, s_addr, s_wdata, s_tsize
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_tsize, s_rdata, s_err,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           s_valid, s_write, s_addr, s_wdata, s_tsize
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction fetch master
// and a load/store master. One transaction at a time: IDLE -> ACCESS -> RESP.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// when undefined the data master wins every conflict (fixed priority).
// All outputs are registered; LATENCY must lie in 1..7.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] LAT_C   = 3'(LATENCY);
  localparam logic [1:0] TSIZE_W = 2'd2;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          owner_d_q, owner_d_d;   // 1: data master owns the access
  logic          s_valid_q, s_valid_d;
  logic          s_write_q, s_write_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;
  logic [1:0]    s_tsize_q, s_tsize_d;
  logic          i_ack_q, i_ack_d;
  logic          i_err_q, i_err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic          d_ack_q, d_ack_d;
  logic          d_err_q, d_err_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          pick_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          last_grant_q, last_grant_d; // 1: last grant went to data master

  // Round-robin: on a conflict the master not granted last time wins
  always_comb begin
    pick_data = bus.d_req && (!bus.i_req || !last_grant_q);
  end
`else
  // Fixed priority: data master wins any conflict
  always_comb begin
    pick_data = bus.d_req;
  end
`endif

  // Next-state, latch and registered-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d_d = owner_d_q;
    s_valid_d = 1'b0;
    s_write_d = 1'b0;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_tsize_d = s_tsize_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    i_rdata_d = '0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    d_rdata_d = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d   = ACCESS;
          cnt_d     = LAT_C;
          owner_d_d = pick_data;
          s_valid_d = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = pick_data;
`endif
          if (pick_data) begin
            s_write_d = bus.d_we;
            s_addr_d  = bus.d_addr;
            s_wdata_d = bus.d_wdata;
            s_tsize_d = bus.d_tsize;
          end else begin
            // Fetches are always word reads with no write data
            s_write_d = 1'b0;
            s_addr_d  = bus.i_addr;
            s_wdata_d = '0;
            s_tsize_d = TSIZE_W;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          // Final slave cycle: capture response straight into the owner's outputs
          state_d = RESP;
          if (owner_d_q) begin
            d_ack_d   = 1'b1;
            d_err_d   = bus.s_err;
            d_rdata_d = s_write_q ? '0 : bus.s_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_err_d   = bus.s_err;
            i_rdata_d = bus.s_rdata;
          end
        end else begin
          s_valid_d = 1'b1;
          s_write_d = s_write_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_d_q <= 1'b0;
      s_valid_q <= 1'b0;
      s_write_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_tsize_q <= '0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_d_q <= owner_d_d;
      s_valid_q <= s_valid_d;
      s_write_q <= s_write_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_tsize_q <= s_tsize_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Grant history for round-robin; reset points at the instruction master
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b0;
    else        last_grant_q <= last_grant_d;
  end
`endif

  assign bus.s_valid = s_valid_q;
  assign bus.s_write = s_write_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
  assign bus.s_tsize = s_tsize_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.i_err   = i_err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_err   = d_err_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances, LATENCY=1 and LATENCY=3.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus3 ();

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  // Memory models: fixed read data, error on the poisoned address
  assign bus1.s_rdata = 32'hDEAD_BEEF;
  assign bus1.s_err   = bus1.s_valid && (bus1.s_addr == 32'hFFFF_FFF0);
  assign bus3.s_rdata = 32'h1234_5678;
  assign bus3.s_err   = bus3.s_valid && (bus3.s_addr == 32'hFFFF_FFF0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; drive and check 1ns after the rising edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_tsize = '0;
    bus3.i_req = 0; bus3.i_addr = '0; bus3.d_req = 0; bus3.d_we = 0;
    bus3.d_addr = '0; bus3.d_wdata = '0; bus3.d_tsize = '0;

    // Reset state
    nxt(); nxt();
    chk("rst_s_valid", 32'(bus1.s_valid), 32'd0);
    chk("rst_i_ack",   32'(bus1.i_ack),   32'd0);
    chk("rst_d_ack",   32'(bus3.d_ack),   32'd0);
    chk("rst_s_addr",  bus3.s_addr,       32'd0);
    chk("rst_s_tsize", 32'(bus3.s_tsize), 32'd0);
    rst_n = 1'b1;
    nxt();

    // Single fetch, LATENCY=1: cycle 0 request
    bus1.i_req = 1; bus1.i_addr = 32'h100;
    nxt(); // cycle 1
    chk("f_s_valid", 32'(bus1.s_valid), 32'd1);
    chk("f_s_addr",  bus1.s_addr,       32'h100);
    chk("f_s_write", 32'(bus1.s_write), 32'd0);
    chk("f_s_tsize", 32'(bus1.s_tsize), 32'd2);
    chk("f_ack_c1",  32'(bus1.i_ack),   32'd0);
    bus1.i_req = 0; // dropped mid-access, ack still due
    nxt(); // cycle 2
    chk("f_i_ack",   32'(bus1.i_ack),   32'd1);
    chk("f_i_rdata", bus1.i_rdata,      32'hDEAD_BEEF);
    chk("f_i_err",   32'(bus1.i_err),   32'd0);
    chk("f_d_ack",   32'(bus1.d_ack),   32'd0);
    chk("f_s_valid2",32'(bus1.s_valid), 32'd0);
    nxt(); // cycle 3
    chk("f_ack_c3",  32'(bus1.i_ack),   32'd0);

    // Byte write, LATENCY=3
    bus3.d_req = 1; bus3.d_we = 1; bus3.d_addr = 32'h204;
    bus3.d_wdata = 32'hAB; bus3.d_tsize = 2'd0;
    for (int c = 1; c <= 3; c++) begin
      nxt();
      chk($sformatf("w_s_write_c%0d", c), 32'(bus3.s_write), 32'd1);
      chk($sformatf("w_s_valid_c%0d", c), 32'(bus3.s_valid), 32'd1);
      chk($sformatf("w_d_ack_c%0d", c),   32'(bus3.d_ack),   32'd0);
    end
    chk("w_s_wdata", bus3.s_wdata,      32'hAB);
    chk("w_s_tsize", 32'(bus3.s_tsize), 32'd0);
    chk("w_s_addr",  bus3.s_addr,       32'h204);
    nxt(); // cycle 4
    chk("w_d_ack",   32'(bus3.d_ack),   32'd1);
    chk("w_d_rdata", bus3.d_rdata,      32'd0);
    chk("w_d_err",   32'(bus3.d_err),   32'd0);
    chk("w_s_write4",32'(bus3.s_write), 32'd0);
    bus3.d_req = 0; bus3.d_we = 0;
    nxt(); // cycle 5
    chk("w_d_ack5",  32'(bus3.d_ack),   32'd0);
    chk("w_s_valid5",32'(bus3.s_valid), 32'd0);
    chk("w_s_addr5", bus3.s_addr,       32'h204);

    // Conflict from reset, LATENCY=1
    rst_n = 1'b0;
    bus1.i_req = 1; bus1.i_addr = 32'h40;
    bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h80; bus1.d_tsize = 2'd2;
    nxt(); nxt();
    rst_n = 1'b1; // cycle 0
    for (int c = 1; c <= 11; c++) begin
      logic exp_i, exp_d;
      nxt();
      exp_i = 1'b0;
      exp_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (c == 2 || c == 8)  exp_d = 1'b1;
      if (c == 5 || c == 11) exp_i = 1'b1;
`else
      if (c == 2 || c == 5 || c == 8 || c == 11) exp_d = 1'b1;
`endif
      chk($sformatf("cf_i_ack_c%0d", c), 32'(bus1.i_ack), 32'(exp_i));
      chk($sformatf("cf_d_ack_c%0d", c), 32'(bus1.d_ack), 32'(exp_d));
    end
    bus1.d_req = 0; // cycle 11: data master stops requesting
    nxt(); // cycle 12: IDLE sees only i_req
    chk("cf_d_ack12", 32'(bus1.d_ack), 32'd0);
    nxt(); // cycle 13
    chk("cf_s_addr13",  bus1.s_addr,       32'h40);
    chk("cf_s_tsize13", 32'(bus1.s_tsize), 32'd2);
    nxt(); // cycle 14
    chk("cf_i_ack14",   32'(bus1.i_ack),   32'd1);
    chk("cf_i_rdata14", bus1.i_rdata,      32'hDEAD_BEEF);
    chk("cf_d_ack14",   32'(bus1.d_ack),   32'd0);
    bus1.i_req = 0;
    nxt();

    // Error propagation, LATENCY=3
    bus3.i_req = 1; bus3.i_addr = 32'hFFFF_FFF0;
    for (int c = 1; c <= 3; c++) begin
      nxt();
      chk($sformatf("e_i_err_c%0d", c), 32'(bus3.i_err), 32'd0);
      chk($sformatf("e_i_ack_c%0d", c), 32'(bus3.i_ack), 32'd0);
    end
    nxt(); // cycle 4
    chk("e_i_ack", 32'(bus3.i_ack), 32'd1);
    chk("e_i_err", 32'(bus3.i_err), 32'd1);
    chk("e_d_err", 32'(bus3.d_err), 32'd0);
    bus3.i_req = 0;
    nxt(); // cycle 5
    chk("e_i_err5", 32'(bus3.i_err), 32'd0);
    chk("e_i_ack5", 32'(bus3.i_ack), 32'd0);

    // Reset mid-access, LATENCY=3
    bus3.d_req = 1; bus3.d_we = 0; bus3.d_addr = 32'h300; bus3.d_tsize = 2'd1;
    nxt(); // cycle 1
    chk("r_s_valid1", 32'(bus3.s_valid), 32'd1);
    chk("r_s_addr1",  bus3.s_addr,       32'h300);
    nxt(); // cycle 2
    rst_n = 1'b0;
    bus3.d_req = 0;
    #1;
    chk("r_s_valid", 32'(bus3.s_valid), 32'd0);
    chk("r_s_addr",  bus3.s_addr,       32'd0);
    chk("r_s_tsize", 32'(bus3.s_tsize), 32'd0);
    chk("r_s_wdata", bus3.s_wdata,      32'd0);
    chk("r_d_ack",   32'(bus3.d_ack),   32'd0);
    nxt();
    nxt();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      nxt();
      chk($sformatf("r_no_ack_%0d", c),   32'(bus3.d_ack),   32'd0);
      chk($sformatf("r_no_valid_%0d", c), 32'(bus3.s_valid), 32'd0);
    end
    bus3.d_req = 1; bus3.d_addr = 32'h310; bus3.d_tsize = 2'd2;
    nxt(); nxt(); nxt(); // cycles 1..3
    chk("r2_s_addr", bus3.s_addr, 32'h310);
    chk("r2_ack3",   32'(bus3.d_ack), 32'd0);
    nxt(); // cycle 4
    chk("r2_d_ack",   32'(bus3.d_ack), 32'd1);
    chk("r2_d_rdata", bus3.d_rdata,    32'h1234_5678);
    chk("r2_d_err",   32'(bus3.d_err), 32'd0);
    bus3.d_req = 0;
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
